// File: rtl/rv32imf_mult_wb_buffer.sv
// Writeback buffer behind the multiplier: queues completed results for the register file
// and discards multicycle results that were flushed while still in flight.
module rv32imf_mult_wb_buffer #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_en_i,
  input  logic [4:0]  mul_rd_i,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_result_i,
  input  logic        flush_i,
  input  logic        wb_ready_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        mul_ex_ready_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        protocol_err_o
);

  typedef enum logic [1:0] {IDLE, MULTI, HOLD, DISCARD} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic [4:0]     mem_rd_q   [DEPTH];
  logic [31:0]    mem_data_q [DEPTH];
  logic [4:0]     last_rd_q;
  logic [31:0]    last_data_q;
  logic [4:0]     rd_q, rd_d;
  logic           err_q, err_d;

  logic full, empty, done, accept, push, pop;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign done   = mul_en_i & mul_ready_i;
  assign accept = done & ~full & (state_q != DISCARD);
  assign push   = accept & (mul_rd_i != 5'd0);
  // a flush wins over a coinciding writeback handshake
  assign pop    = wb_valid_o & wb_ready_i & ~flush_i;

  assign wb_valid_o     = ~empty;
  assign wb_rd_o        = empty ? last_rd_q   : mem_rd_q[rd_ptr_q];
  assign wb_data_o      = empty ? last_data_q : mem_data_q[rd_ptr_q];
  assign mul_ex_ready_o = (state_q == DISCARD) ? 1'b1 : ~full;
  assign stall_o        = mul_en_i & ~accept & (state_q != DISCARD);
  assign busy_o         = ~empty | (state_q != IDLE);
  assign protocol_err_o = err_q;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (mul_en_i & ~mul_ready_i) begin
          state_d = MULTI;
          rd_d    = mul_rd_i;
        end else if (done & full) begin
          state_d = HOLD;
        end
      end
      MULTI: begin
        if (mul_rd_i != rd_q) err_d = 1'b1;
        if (flush_i)           state_d = DISCARD;
        else if (done & ~full) state_d = IDLE;
        else if (done & full)  state_d = HOLD;
      end
      HOLD: begin
        if (flush_i | accept) state_d = IDLE;
      end
      DISCARD: begin
        if (!flush_i && done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      // remember what was last presented so the outputs hold once the FIFO empties
      if (!empty) begin
        last_rd_q   <= mem_rd_q[rd_ptr_q];
        last_data_q <= mem_data_q[rd_ptr_q];
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          mem_rd_q[wr_ptr_q]   <= mul_rd_i;
          mem_data_q[wr_ptr_q] <= mul_result_i;
          wr_ptr_q             <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: doc/rv32imf_mult_wb_buffer.md
Name: rv32imf_mult_wb_buffer

Overview:
- Downstream stage of the integer/DSP multiplier.
- Captures each completed multiply result and its destination register into a small FIFO, then presents it to the register-file writeback port under a valid/ready handshake.
- Drives the multiplier's ex_ready_i back-pressure input.
- Tracks multicycle (MULH) operations so that a flush during a multicycle op discards the in-flight result rather than writing it back.

Parameters:
- DEPTH, 2, FIFO entries (power of two, ≥2).
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mul_en_i  input  1  multiply op present at multiplier this cycle (same signal as multiplier enable_i)
- mul_rd_i  input  5  destination register of current op; stable while mul_en_i is held
- mul_ready_i  input  1  multiplier ready_o
- mul_result_i  input  32  multiplier result_o
- flush_i  input  1  pipeline flush
- wb_ready_i  input  1  regfile write port accepts head entry
- wb_valid_o  output  1  head entry valid
- wb_rd_o  output  5  head destination register
- wb_data_o  output  32  head data
- mul_ex_ready_o  output  1  to multiplier ex_ready_i
- stall_o  output  1  hold the multiply op in EX
- busy_o  output  1  FIFO non-empty or FSM not IDLE
- protocol_err_o  output  1  sticky: mul_rd_i changed during a multicycle op

Behaviour:
- Reset (rst=1 at edge): pointers=0, count=0, FSM=IDLE, protocol_err_o=0. Outputs after reset: wb_valid_o=0, wb_rd_o=0, wb_data_o=0, mul_ex_ready_o=1, stall_o=0, busy_o=0. Reset mid-operation abandons all entries and the FSM, with no writeback.
- full = (count==DEPTH); empty = (count==0).
- Definitions:
  - done = mul_en_i & mul_ready_i.
  - accept = done & ~full & (state!=DISCARD).
  - push = accept & (mul_rd_i!=0).
  - pop = wb_valid_o & wb_ready_i.
- An rd=0 result completes the handshake but is not pushed.
- mul_ex_ready_o = ~full (combinational from registered count). In DISCARD it is forced to 1.
- stall_o = mul_en_i & ~accept & (state!=DISCARD).
- Latency: a result pushed at edge N is visible at wb_valid_o/wb_data_o after edge N (registered FIFO storage). There is no combinational bypass.
- Simultaneous push and pop: count unchanged; both pointers advance modulo DEPTH. Pointers wrap from DEPTH-1 to 0.
- Pop when empty cannot occur (wb_valid_o=0). Push when full is blocked by the accept term.
- wb_rd_o/wb_data_o show the head entry when valid and hold their last value when empty.
- FSM states:
  - IDLE:
    - mul_en_i & ~mul_ready_i → MULTI; latch mul_rd_i into rd_q.
    - done & full → HOLD.
    - Otherwise stay in IDLE.
  - MULTI:
    - Waiting for a MULH to finish.
    - mul_rd_i != rd_q sets protocol_err_o (sticky until rst).
    - flush_i → DISCARD.
    - done & ~full → IDLE.
    - done & full → HOLD.
  - HOLD:
    - Result ready but FIFO full; the multiplier stays in FINISH because ex_ready=0.
    - flush_i → IDLE (result dropped).
    - accept → IDLE.
  - DISCARD:
    - Flushed multicycle op still running.
    - done → IDLE with no push.
    - flush_i again → stay in DISCARD.
- flush_i (any state): count, pointers and wb_valid_o are cleared at the same edge. A pop coinciding with a flush is ignored (wb_ready_i is not honoured that cycle). A push coinciding with a flush is dropped.
- busy_o = ~empty | (state!=IDLE).

Test Plan:
- Single-cycle MUL, rd=5, result 0x0000_0C00, wb_ready_i=1:
  - stall_o=0 in the issue cycle.
  - wb_valid_o=1 with rd=5, data=0x0000_0C00 one cycle later.
  - busy_o=0 the following cycle.
- MULH with mul_ready_i low for 4 cycles, then high, rd=7, result 0xFFFF_FFFE:
  - FSM in MULTI, stall_o=1 for 4 cycles.
  - Push on the 5th cycle; writeback data 0xFFFF_FFFE.
- wb_ready_i=0, three back-to-back ops (rd 1,2,3) with DEPTH=2:
  - After two pushes mul_ex_ready_o=0; third op stalls in HOLD.
  - Raise wb_ready_i: drains rd1, then rd3 is accepted into the freed slot, then rd2, then rd3 are written back in order.
- flush_i in MULTI, 2 cycles before mul_ready_i rises:
  - FSM → DISCARD, mul_ex_ready_o=1, no writeback occurs.
  - FSM returns to IDLE one cycle after done.
- Op with rd=0, result 0x1234_5678: accept, stall_o=0, no wb_valid_o, count stays 0.
- mul_rd_i changes 3→4 during MULTI: protocol_err_o=1 the next cycle, and it stays 1 until rst=1.
